// File: rtl/matrix_reader.sv
// matrix_reader: read-side engine for a 256x32 matrix store.
// Given a base address and row/column counts, walks the elements in row-major
// order and presents them one at a time with valid/ready handshaking plus
// row/column tags. Never writes the store.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   start                  one-cycle request, only looked at while idle
//   base_addr, rows, cols  matrix location and shape, latched on acceptance
//   st_addr / st_data      registered read address, combinational read data
//   out_data/out_row/out_col  current element and its indices
//   out_valid / out_ready  element handshake
//   out_eol / out_last     end of row / final element, qualified by out_valid
//   busy                   high while fetching or holding an element
//   done                   one-cycle pulse after the final element is accepted
//   err                    one-cycle pulse when a start request is rejected
module matrix_reader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DIM_W   = 3,
    parameter int unsigned MAX_DIM = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    output logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] out_data,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_eol,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDone} state_e;

    // One extra bit so the end-address check cannot wrap.
    localparam int unsigned EXT_W = ADDR_W + 1;
    localparam logic [DIM_W-1:0]  DimOne  = DIM_W'(1);
    localparam logic [DIM_W-1:0]  MaxDim  = DIM_W'(MAX_DIM);
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DIM_W-1:0]  orow_q, orow_d;
    logic [DIM_W-1:0]  ocol_q, ocol_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [EXT_W-1:0]  end_addr;
    logic              dims_ok;
    logic              range_ok;
    logic              at_eol;
    logic              at_last;

    always_comb begin
        dims_ok  = (rows != '0) && (rows <= MaxDim) && (cols != '0) && (cols <= MaxDim);
        end_addr = {1'b0, base_addr} + (EXT_W'(rows) * EXT_W'(cols)) - EXT_W'(1);
        range_ok = ~end_addr[ADDR_W];
        at_eol   = (col_q == cols_q - DimOne);
        at_last  = at_eol && (row_q == rows_q - DimOne);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        col_d   = col_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        data_d  = data_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (dims_ok && range_ok) begin
                        rows_d  = rows;
                        cols_d  = cols;
                        addr_d  = base_addr;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = StFetch;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                // st_data is combinational from the address registered last cycle.
                data_d  = st_data;
                orow_d  = row_q;
                ocol_d  = col_q;
                valid_d = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (at_last) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        addr_d = addr_q + AddrOne;
                        if (at_eol) begin
                            col_d = '0;
                            row_d = row_q + DimOne;
                        end else begin
                            col_d = col_q + DimOne;
                        end
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            data_q  <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            data_q  <= data_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign st_addr   = addr_q;
    assign out_data  = data_q;
    assign out_row   = orow_q;
    assign out_col   = ocol_q;
    assign out_valid = valid_q;
    assign out_eol   = valid_q && (ocol_q == cols_q - DimOne);
    assign out_last  = out_eol && (orow_q == rows_q - DimOne);
    assign busy      = (state_q == StFetch) || (state_q == StHold);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_reader.sv
module tb_matrix_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        eol;
        logic        last;
    } elem_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [2:0]  rows;
    logic [2:0]  cols;
    logic [7:0]  st_addr;
    logic [31:0] st_data;
    logic [31:0] out_data;
    logic [2:0]  out_row;
    logic [2:0]  out_col;
    logic        out_valid;
    logic        out_ready;
    logic        out_eol;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] mem [256];
    int vectors;
    int miscompares;

    matrix_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .rows      (rows),
        .cols      (cols),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_eol   (out_eol),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    assign st_data = mem[st_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: row-major walk of the matrix straight from the storage model.
    function automatic void model(input int b, input int r, input int c, output elem_t q[$]);
        q.delete();
        for (int rr = 0; rr < r; rr++) begin
            for (int cc = 0; cc < c; cc++) begin
                q.push_back('{data: mem[b + rr * c + cc], row: 3'(rr), col: 3'(cc),
                              eol: (cc == c - 1), last: (rr == r - 1) && (cc == c - 1)});
            end
        end
    endfunction

    // Present a start request; it is sampled at the next rising edge.
    task automatic kick(input int b, input int r, input int c);
        @(posedge clk);
        #1;
        base_addr = 8'(b);
        rows      = 3'(r);
        cols      = 3'(c);
        start     = 1'b1;
    endtask

    // Runs the consumer side after kick(); cycle 1 is the edge that samples start.
    // ready_mode: 0 always ready, 1 ready one cycle in three, 2 random.
    // inj_cycle: cycle at which a stray start (base 0, 1x1) is pulsed, 0 for none.
    task automatic collect(input int ready_mode, input int inj_cycle,
                           output elem_t got[$], output int cyc_q[$], output int done_cyc,
                           output int stall_bad, output int err_cnt, output logic [7:0] addr_at_done);
        int    cyc;
        logic  prev_stall;
        elem_t prev;
        elem_t cur;
        cyc = 0;
        prev_stall = 1'b0;
        prev = '0;
        got.delete();
        cyc_q.delete();
        done_cyc = -1;
        stall_bad = 0;
        err_cnt = 0;
        addr_at_done = '0;
        while (cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == inj_cycle);
            if (cyc == inj_cycle) begin
                base_addr = 8'd0;
                rows      = 3'd1;
                cols      = 3'd1;
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            cur = '{data: out_data, row: out_row, col: out_col, eol: out_eol, last: out_last};
            if (prev_stall && (!out_valid || cur !== prev)) stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev = cur;
            if (err) err_cnt++;
            if (out_valid && out_ready) begin
                got.push_back(cur);
                cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cyc = cyc;
                addr_at_done = st_addr;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({st_addr, out_data, out_row, out_col, out_valid, out_eol, out_last, busy, done, err}
            !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got addr=%h data=%h valid=%b busy=%b done=%b err=%b, expected all 0",
                     st_addr, out_data, out_valid, busy, done, err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // T1: 2x3 at base 10, always ready; checks contents, tags and exact timing.
    task automatic test_basic();
        elem_t exp[$];
        elem_t got[$];
        int cq[$];
        int dc, sb, ec;
        logic [7:0] ad;
        model(10, 2, 3, exp);
        kick(10, 2, 3);
        collect(0, 0, got, cq, dc, sb, ec, ad);
        vectors++;
        if (got.size() != 6 || dc < 0) begin
            miscompares++;
            $display("FAIL t1_count: got %0d elements done_cyc=%0d, expected 6 and done", got.size(), dc);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i] || cq[i] != 2 + 2 * i) begin
                miscompares++;
                $display("FAIL t1_elem %0d: got %h at cycle %0d, expected %h at cycle %0d",
                         i, got[i], cq[i], exp[i], 2 + 2 * i);
            end
        end
        vectors++;
        if (dc != 13 || ad !== 8'd15) begin
            miscompares++;
            $display("FAIL t1_done: got cycle %0d addr %0d, expected cycle 13 addr 15", dc, ad);
        end
        @(posedge clk);
        #2;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_done_pulse: got done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    // T2: same matrix with ready high one cycle in three.
    task automatic test_backpressure();
        elem_t exp[$];
        elem_t got[$];
        int cq[$];
        int dc, sb, ec;
        logic [7:0] ad;
        model(10, 2, 3, exp);
        kick(10, 2, 3);
        collect(1, 0, got, cq, dc, sb, ec, ad);
        vectors++;
        if (got.size() != exp.size() || sb != 0) begin
            miscompares++;
            $display("FAIL t2_stream: got %0d elements, %0d stall changes, expected 6 and 0",
                     got.size(), sb);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL t2_elem %0d: got %h, expected %h", i, got[i], exp[i]);
            end
        end
        vectors++;
        if (cq.size() == 0 || dc != cq[cq.size() - 1] + 1) begin
            miscompares++;
            $display("FAIL t2_done: got done cycle %0d, expected one after last handshake", dc);
        end
    endtask

    // T3: rejected requests, then the largest legal request.
    task automatic test_errors();
        int tb [5][3] = '{'{0, 0, 3}, '{0, 3, 6}, '{232, 5, 5}, '{0, 6, 1}, '{100, 7, 2}};
        elem_t exp[$];
        elem_t got[$];
        int cq[$];
        int dc, sb, ec;
        logic [7:0] ad;
        for (int i = 0; i < 9; i++) begin
            int r, c, b;
            if (i < 5) begin
                b = tb[i][0]; r = tb[i][1]; c = tb[i][2];
            end else begin
                r = $urandom_range(1, 5);
                c = $urandom_range(1, 5);
                b = 257 - r * c + $urandom_range(0, r * c - 2 + 1);
                if (b > 255) b = 255;
                if (r * c == 1) r = 2;
            end
            kick(b, r, c);
            @(posedge clk);
            #1;
            start = 1'b0;
            #1;
            vectors++;
            if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL t3_reject b=%0d r=%0d c=%0d: got err=%b busy=%b valid=%b, expected 1 0 0",
                         b, r, c, err, busy, out_valid);
            end
            @(posedge clk);
            #2;
            vectors++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL t3_err_pulse: got err=%b busy=%b, expected 0 0", err, busy);
            end
        end
        model(231, 5, 5, exp);
        kick(231, 5, 5);
        collect(2, 0, got, cq, dc, sb, ec, ad);
        vectors++;
        if (got.size() != 25 || ad !== 8'd255 || ec != 0 || sb != 0) begin
            miscompares++;
            $display("FAIL t3_max: got %0d elements addr %0d err %0d stall %0d, expected 25 255 0 0",
                     got.size(), ad, ec, sb);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL t3_elem %0d: got %h, expected %h", i, got[i], exp[i]);
            end
        end
    endtask

    // T4: stray start mid-stream must be ignored.
    task automatic test_start_busy();
        elem_t exp[$];
        elem_t got[$];
        int cq[$];
        int dc, sb, ec;
        logic [7:0] ad;
        model(10, 2, 3, exp);
        kick(10, 2, 3);
        collect(0, 4, got, cq, dc, sb, ec, ad);
        vectors++;
        if (got.size() != 6 || dc != 13 || ec != 0) begin
            miscompares++;
            $display("FAIL t4_ignore: got %0d elements done %0d err %0d, expected 6 13 0",
                     got.size(), dc, ec);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL t4_elem %0d: got %h, expected %h", i, got[i], exp[i]);
            end
        end
        @(posedge clk);
        #2;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_idle: got busy=%b valid=%b, expected 0 0", busy, out_valid);
        end
    endtask

    // T5: asynchronous reset after the second handshake, then a clean restart.
    task automatic test_reset_mid();
        elem_t exp[$];
        elem_t got[$];
        int cq[$];
        int dc, sb, ec, hs;
        logic [7:0] ad;
        hs = 0;
        kick(10, 2, 3);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && hs < 2; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            #1;
            if (out_valid && out_ready) hs++;
        end
        vectors++;
        if (hs != 2) begin
            miscompares++;
            $display("FAIL t5_handshakes: got %0d, expected 2", hs);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({st_addr, out_data, out_row, out_col, out_valid, out_eol, out_last, busy, done, err}
            !== '0) begin
            miscompares++;
            $display("FAIL t5_async_reset: got addr=%h data=%h valid=%b busy=%b, expected all 0",
                     st_addr, out_data, out_valid, busy);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model(10, 2, 3, exp);
        kick(10, 2, 3);
        collect(0, 0, got, cq, dc, sb, ec, ad);
        vectors++;
        if (got.size() != 6 || dc != 13) begin
            miscompares++;
            $display("FAIL t5_restart: got %0d elements done %0d, expected 6 13", got.size(), dc);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL t5_elem %0d: got %h, expected %h", i, got[i], exp[i]);
            end
        end
    endtask

    // T6: 1x1 matrix.
    task automatic test_single();
        elem_t exp[$];
        elem_t got[$];
        int cq[$];
        int dc, sb, ec;
        logic [7:0] ad;
        mem[0] = 32'hDEADBEEF;
        exp.delete();
        exp.push_back('{data: 32'hDEADBEEF, row: 3'd0, col: 3'd0, eol: 1'b1, last: 1'b1});
        kick(0, 1, 1);
        collect(0, 0, got, cq, dc, sb, ec, ad);
        vectors++;
        if (got.size() != 1 || dc != 3) begin
            miscompares++;
            $display("FAIL t6_count: got %0d elements done %0d, expected 1 3", got.size(), dc);
        end
        if (got.size() > 0) begin
            vectors++;
            if (got[0] !== exp[0]) begin
                miscompares++;
                $display("FAIL t6_elem: got %h, expected %h", got[0], exp[0]);
            end
        end
    endtask

    // Random legal shapes and bases with random backpressure.
    task automatic test_random();
        elem_t exp[$];
        elem_t got[$];
        int cq[$];
        int dc, sb, ec;
        logic [7:0] ad;
        for (int n = 0; n < 8; n++) begin
            int r, c, b;
            r = $urandom_range(1, 5);
            c = $urandom_range(1, 5);
            b = (n % 2 == 0) ? 256 - r * c : $urandom_range(0, 256 - r * c);
            model(b, r, c, exp);
            kick(b, r, c);
            collect(2, 0, got, cq, dc, sb, ec, ad);
            vectors++;
            if (got.size() != exp.size() || sb != 0 || ec != 0 || ad !== 8'(b + r * c - 1)) begin
                miscompares++;
                $display("FAIL rand_shape b=%0d r=%0d c=%0d: got %0d elements stall %0d err %0d addr %0d",
                         b, r, c, got.size(), sb, ec, ad);
            end
            for (int i = 0; i < exp.size() && i < got.size(); i++) begin
                vectors++;
                if (got[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL rand_elem %0d: got %h, expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        rows        = '0;
        cols        = '0;
        out_ready   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 6; i++) mem[10 + i] = 32'(i + 1);
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_start_busy();
        test_reset_mid();
        test_single();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
